// File: rtl/wb_led_sequencer.sv
// Wishbone-controlled LED pattern sequencer: four programmable steps, each showing
// an 8-bit pattern for (PRESCALE+1)*(HOLD+1) cycles, cyclic or one-shot.
module wb_led_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  io_out,
  output logic [7:0]  io_oeb
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Register file
  logic        en_q, en_d, oneshot_q, oneshot_d;
  logic [15:0] prescale_q, prescale_d;
  logic [7:0]  pat_q [4];
  logic [7:0]  pat_d [4];
  logic [7:0]  step_hold_q [4];
  logic [7:0]  step_hold_d [4];

  // Bus response
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;

  // Sequencer
  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [7:0]  led_q, led_d;

  logic        hit, req, wr;
  logic [5:0]  word;
  logic [31:0] rdata;
  logic        tick;
  logic [1:0]  next_step;

  // Byte lane 3 and the sub-word address bits carry nothing for these registers.
  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3], wbs_dat_i[31:24]};

  assign hit  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req  = wbs_cyc_i & wbs_stb_i & ~ack_q & hit;
  assign wr   = req & wbs_we_i;
  assign word = wbs_adr_i[7:2];

  // Register writes land on the edge that raises ack
  always_comb begin
    en_d       = en_q;
    oneshot_d  = oneshot_q;
    prescale_d = prescale_q;
    pat_d       = pat_q;
    step_hold_d = step_hold_q;
    if (wr) begin
      if (word == 6'h00 && wbs_sel_i[0]) begin
        en_d      = wbs_dat_i[0];
        oneshot_d = wbs_dat_i[1];
      end
      if (word == 6'h01) begin
        if (wbs_sel_i[0]) prescale_d[7:0]  = wbs_dat_i[7:0];
        if (wbs_sel_i[1]) prescale_d[15:8] = wbs_dat_i[15:8];
      end
      for (int i = 0; i < 4; i++) begin
        if (word == 6'(i + 2)) begin
          if (wbs_sel_i[0]) pat_d[i]       = wbs_dat_i[7:0];
          if (wbs_sel_i[2]) step_hold_d[i] = wbs_dat_i[23:16];
        end
      end
    end
  end

  // Read mux; unmapped offsets and unused bits read as zero
  always_comb begin
    rdata = 32'h0;
    case (word)
      6'h00: rdata = {30'h0, oneshot_q, en_q};
      6'h01: rdata = {16'h0, prescale_q};
      6'h02: rdata = {8'h0, step_hold_q[0], 8'h0, pat_q[0]};
      6'h03: rdata = {8'h0, step_hold_q[1], 8'h0, pat_q[1]};
      6'h04: rdata = {8'h0, step_hold_q[2], 8'h0, pat_q[2]};
      6'h05: rdata = {8'h0, step_hold_q[3], 8'h0, pat_q[3]};
      6'h06: rdata = {28'h0, state_q == StRun, state_q == StDone, step_q};
      default: rdata = 32'h0;
    endcase
    ack_d = req;
    dat_d = (req && !wbs_we_i) ? rdata : 32'h0;
  end

  // Step sequencing: prescaler ticks feed the hold counter, hold match advances the step
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    pre_cnt_d  = pre_cnt_q;
    hold_cnt_d = hold_cnt_q;
    led_d      = led_q;
    // Equality compare: a PRESCALE lowered below the count lets it wrap through 16'hFFFF.
    tick       = (pre_cnt_q == prescale_q);
    next_step  = step_q + 2'd1;
    unique case (state_q)
      StIdle: begin
        step_d     = 2'd0;
        pre_cnt_d  = 16'h0;
        hold_cnt_d = 8'h0;
        led_d      = 8'h00;
        if (en_q) begin
          state_d = StRun;
          led_d   = pat_q[0];
        end
      end
      StRun: begin
        if (!en_q) begin
          state_d    = StIdle;
          step_d     = 2'd0;
          pre_cnt_d  = 16'h0;
          hold_cnt_d = 8'h0;
          led_d      = 8'h00;
        end else begin
          pre_cnt_d = tick ? 16'h0 : pre_cnt_q + 16'd1;
          if (tick) begin
            // Live HOLD of the active step, so edits apply at the next compare.
            if (hold_cnt_q == step_hold_q[step_q]) begin
              hold_cnt_d = 8'h0;
              if (step_q == 2'd3 && oneshot_q) begin
                state_d = StDone;
              end else begin
                step_d = next_step;
                led_d  = pat_q[next_step];
              end
            end else begin
              hold_cnt_d = hold_cnt_q + 8'd1;
            end
          end
        end
      end
      StDone: begin
        if (!en_q) begin
          state_d    = StIdle;
          step_d     = 2'd0;
          pre_cnt_d  = 16'h0;
          hold_cnt_d = 8'h0;
          led_d      = 8'h00;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      en_q        <= 1'b0;
      oneshot_q   <= 1'b0;
      prescale_q  <= 16'h0;
      pat_q       <= '{default: 8'h0};
      step_hold_q <= '{default: 8'h0};
      ack_q       <= 1'b0;
      dat_q       <= 32'h0;
      state_q     <= StIdle;
      step_q      <= 2'd0;
      pre_cnt_q   <= 16'h0;
      hold_cnt_q  <= 8'h0;
      led_q       <= 8'h00;
    end else begin
      en_q        <= en_d;
      oneshot_q   <= oneshot_d;
      prescale_q  <= prescale_d;
      pat_q       <= pat_d;
      step_hold_q <= step_hold_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      state_q     <= state_d;
      step_q      <= step_d;
      pre_cnt_q   <= pre_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      led_q       <= led_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = led_q;
  assign io_oeb    = 8'h00;

endmodule

// File: tb/tb_wb_led_sequencer.sv
// Directed bench for wb_led_sequencer: register access, cyclic, one-shot, abort,
// minimum timing, byte lanes and reset behaviour.
module tb_wb_led_sequencer;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [7:0]  OFS_CTRL = 8'h00, OFS_PRE = 8'h04, OFS_STEP0 = 8'h08;
  localparam logic [7:0]  OFS_STEP1 = 8'h0C, OFS_STEP2 = 8'h10, OFS_STEP3 = 8'h14;
  localparam logic [7:0]  OFS_STAT = 8'h18, OFS_UNMAP = 8'h1C;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w;
  logic        ack;
  logic [31:0] dat_r;
  logic [7:0]  io_out, io_oeb;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  pats [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
  logic [31:0] rd;
  logic        seen;

  always #5 clk = ~clk;

  wb_led_sequencer #(.BASE_ADDR(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_w),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_r),
    .io_out    (io_out),
    .io_oeb    (io_oeb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns #1 after the edge that raised ack (the write edge).
  task automatic wb_xfer(input logic w, input logic [7:0] ofs, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] q);
    logic got;
    got = 1'b0;
    q   = 32'h0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = BASE + {24'h0, ofs}; dat_w = d; sel = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        q   = dat_r;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk(w ? "wr_ack" : "rd_ack", {31'h0, got}, 32'h1);
  endtask

  task automatic wr(input logic [7:0] ofs, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, ofs, d, 4'hF, dummy);
  endtask

  task automatic rdreg(input logic [7:0] ofs, output logic [31:0] q);
    wb_xfer(1'b0, ofs, 32'h0, 4'hF, q);
  endtask

  task automatic tick1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat_w = 32'h0;
    repeat (3) tick1();
    chk("rst_io_out", {24'h0, io_out}, 32'h0);
    chk("rst_io_oeb", {24'h0, io_oeb}, 32'h0);
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_dat", dat_r, 32'h0);
    rst = 1'b0;
    tick1();

    // Register access
    wr(OFS_CTRL, 32'hFFFF_FFFE);  rdreg(OFS_CTRL, rd);  chk("ctrl_rb", rd, 32'h0000_0002);
    tick1();
    chk("ack_pulse", {31'h0, ack}, 32'h0);
    chk("dat_idle", dat_r, 32'h0);
    wr(OFS_CTRL, 32'h0);
    wr(OFS_PRE, 32'hABCD_1234);   rdreg(OFS_PRE, rd);   chk("pre_rb", rd, 32'h0000_1234);
    wr(OFS_STEP0, 32'hFFFF_FFFF); rdreg(OFS_STEP0, rd); chk("step0_rb", rd, 32'h00FF_00FF);
    wr(OFS_STEP1, 32'h00AB_00CD); rdreg(OFS_STEP1, rd); chk("step1_rb", rd, 32'h00AB_00CD);
    wr(OFS_STEP2, 32'h1234_5678); rdreg(OFS_STEP2, rd); chk("step2_rb", rd, 32'h0034_0078);
    wr(OFS_STEP3, 32'hFFFF_FF00); rdreg(OFS_STEP3, rd); chk("step3_rb", rd, 32'h00FF_0000);
    wr(OFS_STAT, 32'hFFFF_FFFF);  rdreg(OFS_STAT, rd);  chk("status_idle", rd, 32'h0);
    wr(OFS_UNMAP, 32'hFFFF_FFFF); rdreg(OFS_UNMAP, rd); chk("unmapped_rd", rd, 32'h0);

    // Outside the window: never acked
    seen = 1'b0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h100;
    repeat (4) begin
      tick1();
      if (ack) seen = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("oow_noack", {31'h0, seen}, 32'h0);

    // Cyclic run, 8 cycles per step
    wr(OFS_PRE, 32'd3);
    wr(OFS_STEP0, 32'h0001_0001); wr(OFS_STEP1, 32'h0001_0002);
    wr(OFS_STEP2, 32'h0001_0004); wr(OFS_STEP3, 32'h0001_0008);
    wr(OFS_CTRL, 32'h1);
    chk("cyc_idle_at_write", {24'h0, io_out}, 32'h0);
    for (int k = 0; k < 40; k++) begin
      tick1();
      chk("cyc_seq", {24'h0, io_out}, {24'h0, pats[(k / 8) % 4]});
    end
    wr(OFS_CTRL, 32'h0);
    tick1();
    chk("cyc_stop", {24'h0, io_out}, 32'h0);

    // One-shot
    wr(OFS_CTRL, 32'h3);
    for (int k = 0; k < 40; k++) begin
      tick1();
      chk("os_seq", {24'h0, io_out}, {24'h0, (k < 32) ? pats[k / 8] : 8'h08});
    end
    rdreg(OFS_STAT, rd); chk("os_status", rd, 32'h0000_0007);
    chk("os_hold", {24'h0, io_out}, 32'h08);
    wr(OFS_CTRL, 32'h2);
    chk("os_still08", {24'h0, io_out}, 32'h08);
    tick1();
    chk("os_exit", {24'h0, io_out}, 32'h0);

    // Abort during step 2
    wr(OFS_CTRL, 32'h1);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick1();
      if (io_out == 8'h04) seen = 1'b1;
    end
    chk("abort_reach_step2", {31'h0, seen}, 32'h1);
    rdreg(OFS_STAT, rd); chk("abort_status_run", rd, 32'h0000_000A);
    wr(OFS_CTRL, 32'h0);
    tick1();
    chk("abort_io", {24'h0, io_out}, 32'h0);
    rdreg(OFS_STAT, rd); chk("abort_status", rd, 32'h0);

    // Minimum timing: one cycle per step
    wr(OFS_PRE, 32'd0);
    wr(OFS_STEP0, 32'h01); wr(OFS_STEP1, 32'h02); wr(OFS_STEP2, 32'h04); wr(OFS_STEP3, 32'h08);
    wr(OFS_CTRL, 32'h1);
    for (int k = 0; k < 8; k++) begin
      tick1();
      chk("min_seq", {24'h0, io_out}, {24'h0, pats[k % 4]});
    end
    wr(OFS_CTRL, 32'h0);
    tick1();
    chk("min_abort", {24'h0, io_out}, 32'h0);
    rdreg(OFS_STAT, rd); chk("min_status", rd, 32'h0);

    // Byte lanes
    wr(OFS_STEP0, 32'h0);
    begin
      logic [31:0] dummy;
      wb_xfer(1'b1, OFS_STEP0, 32'hFFFF_FFFF, 4'b0001, dummy);
    end
    rdreg(OFS_STEP0, rd); chk("sel_lane0", rd, 32'h0000_00FF);

    // Reset while running
    wr(OFS_CTRL, 32'h1);
    repeat (3) tick1();
    chk("rst_run_active", {31'h0, io_out != 8'h00}, 32'h1);
    rst = 1'b1;
    tick1();
    chk("rst_run_io", {24'h0, io_out}, 32'h0);
    chk("rst_run_ack", {31'h0, ack}, 32'h0);
    rst = 1'b0;
    tick1();
    chk("rst_run_idle", {24'h0, io_out}, 32'h0);
    rdreg(OFS_CTRL, rd);  chk("rst_ctrl", rd, 32'h0);
    rdreg(OFS_PRE, rd);   chk("rst_pre", rd, 32'h0);
    rdreg(OFS_STEP0, rd); chk("rst_step0", rd, 32'h0);
    rdreg(OFS_STEP1, rd); chk("rst_step1", rd, 32'h0);
    rdreg(OFS_STEP2, rd); chk("rst_step2", rd, 32'h0);
    rdreg(OFS_STEP3, rd); chk("rst_step3", rd, 32'h0);

    // Reset coinciding with a write request: write lost, no ack
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'h4; dat_w = 32'h1234;
    rst = 1'b1;
    tick1();
    chk("rst_xfer_ack", {31'h0, ack}, 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
    rdreg(OFS_PRE, rd); chk("rst_xfer_lost", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_led_sequencer.md
WB_LED_SEQUENCER -- requirements
Module: wb_led_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, the Wishbone base address of the register block.
REQ-002 SHALL have port wb_clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port wb_rst_i, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have Wishbone slave inputs wbs_stb_i (1), wbs_cyc_i (1), wbs_we_i (1), wbs_sel_i (4), wbs_adr_i (32) and wbs_dat_i (32).
REQ-005 SHALL have port wbs_ack_o, output, 1, the transfer acknowledge.
REQ-006 SHALL have port wbs_dat_o, output, 32, the read data.
REQ-007 SHALL have port io_out, output, 8, the LED drive.
REQ-008 SHALL have port io_oeb, output, 8, the output enables (active-low).

Function
REQ-009 SHALL implement these registers at BASE_ADDR plus the listed offset:
- 0x00 CTRL: bit0 EN, bit1 ONESHOT.
- 0x04 PRESCALE[15:0].
- 0x08/0x0C/0x10/0x14 STEP0..3: [7:0] PAT, [23:16] HOLD.
- 0x18 STATUS (read-only): [1:0] step index, bit2 DONE, bit3 RUN.
Unused bits read 0.
REQ-010 SHALL accept a request when wbs_cyc_i & wbs_stb_i & !wbs_ack_o.
- It asserts wbs_ack_o on the next edge for exactly one cycle.
- Back-to-back requests are therefore acked every other cycle.
REQ-011 SHALL perform register writes on the edge at which wbs_ack_o rises, honouring wbs_sel_i byte lanes.
REQ-012 SHALL present read data on wbs_dat_o together with wbs_ack_o, and drive wbs_dat_o to 0 otherwise.
REQ-013 SHALL ack unmapped offsets (0x1C and above within the 256-byte window); reads return 0 and writes are ignored.
REQ-014 SHALL ignore requests outside the BASE_ADDR 256-byte window: no ack.
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 IDLE: io_out = 8'h00, prescaler and hold counters held at 0, step = 0.
- EN=1 observed moves the FSM to RUN on the next edge and loads STEP0.
- On that same edge io_out = STEP0.PAT.
REQ-017 RUN: the prescaler counts 0..PRESCALE and produces a one-cycle tick when it wraps.
- Each tick increments the hold counter.
- When the hold counter reaches HOLD and a tick occurs, the FSM advances the step.
- Each step therefore lasts exactly (PRESCALE+1)*(HOLD+1) cycles.
REQ-018 Step advance: step n -> n+1 and io_out = STEPn+1.PAT on the same edge.
- From step 3: if ONESHOT=0, wrap to step 0; if ONESHOT=1, go to DONE.
REQ-019 DONE: io_out holds STEP3.PAT, DONE=1, counters frozen.
- EN=0 moves the FSM to IDLE on the next edge.
- DONE stays set until EN is cleared or reset.
REQ-020 EN=0 in RUN SHALL move the FSM to IDLE on the next edge, aborting the step.
- If a step advance is due on that same edge, IDLE wins.
REQ-021 Writes to STEPn SHALL NOT change io_out immediately.
- The new PAT/HOLD takes effect when step n is next loaded.
- A write to the currently active step's HOLD takes effect on the next hold comparison.
REQ-022 Writes to PRESCALE during RUN SHALL take effect at the next prescaler compare.
- If the counter already exceeds the new value, it wraps at 16'hFFFF.
REQ-023 PRESCALE=0 with HOLD=0 SHALL give a one-cycle step; the FSM advances every cycle.
REQ-024 io_oeb SHALL be driven to 8'h00 at all times after reset.
REQ-025 All counters SHALL be unsigned.
- Prescaler width: 16 bits. Hold counter width: 8 bits.
- No count overflows before its compare.

Reset
REQ-026 Synchronous wb_rst_i=1 SHALL force, on the next edge:
- FSM to IDLE;
- CTRL, PRESCALE and STEP0..3 to 0;
- wbs_ack_o = 0, wbs_dat_o = 0, io_out = 8'h00, io_oeb = 8'h00;
- all counters to 0.
REQ-027 Reset asserted mid-transfer SHALL drop any pending ack; that write is lost.
REQ-028 Reset asserted in RUN SHALL return the FSM to IDLE with no further io_out change.

Verification
REQ-029 Register access: write then read back each register (STEP1 = 32'h00AB_00CD).
- Reads return the written value with upper-byte masking applied: STEP1 reads 32'h00AB_00CD.
- Ack is a one-cycle pulse.
- Offset 0x1C reads 0 and is acked.
REQ-030 Cyclic run: PRESCALE=3; STEPn.PAT = 8'h01/02/04/08; HOLD=1; EN=1.
- io_out goes 01->02->04->08->01 with each value lasting exactly 8 cycles.
REQ-031 Oneshot: same setup plus ONESHOT=1.
- After 08 has been held 8 cycles: state DONE, STATUS = 4'b0111, io_out stays 8'h08.
- EN=0 -> io_out = 8'h00 the next cycle.
REQ-032 Abort: clear EN during step 2.
- io_out = 8'h00 one cycle after the write ack.
- STATUS step reads 0.
REQ-033 Minimum timing: PRESCALE=0, all HOLD=0.
- io_out changes every cycle.
- Simultaneous EN=0 write and advance -> IDLE.
REQ-034 Byte lanes and reset: wbs_sel_i=4'b0001 write of 32'hFFFF_FFFF to STEP0 -> reads 32'h0000_00FF.
- wb_rst_i pulse during RUN -> all registers 0, io_out = 8'h00 the next edge.
